rf_transfer_controller: RTL and testbench
=========================================

RF_TRANSFER_CONTROLLER -- requirements
Module: rf_transfer_controller

Interface
REQ-001 SHALL have one clock and an asynchronous active-high reset: Clock input 1, all state on the rising edge; Reset input 1, async active-high.
REQ-002 SHALL have ports: CmdValid input 1, command offered; CmdReady output 1, command accepted when high with CmdValid.
REQ-003 SHALL have ports: CmdSrcA input 3, read code for port A; CmdSrcB input 3, read code for port B; CmdDst input 3, write code; CmdFun input 3, FunSel for the write; CmdWrite input 1, 1 = perform write.
REQ-004 SHALL have ports: RfOutA input 32, register-file port A data; RfOutB input 32, register-file port B data.
REQ-005 SHALL have ports: OutASel output 3; OutBSel output 3; FunSel output 3; RegSel output 4; ScrSel output 4; all drive the register file.
REQ-006 SHALL have ports: RspValid output 1; RspReady input 1; RspA output 32; RspB output 32; CmdCount output 8, completed-command count.
REQ-007 SHALL use register codes 000-011 = R1-R4 and 100-111 = S1-S4.

Function
REQ-008 SHALL implement FSM states IDLE, SEL, CAPTURE, WRITE, RESP.
REQ-009 SHALL assert CmdReady only in IDLE with Reset low; handshake = CmdValid & CmdReady at a rising edge.
REQ-010 SHALL latch all Cmd* fields on handshake, move to SEL, and ignore Cmd* inputs until the next IDLE.
REQ-011 SHALL drive OutASel/OutBSel from the latched SrcA/SrcB in SEL, CAPTURE and WRITE; hold the last values elsewhere.
REQ-012 SHALL always move SEL -> CAPTURE; CAPTURE SHALL register RfOutA->RspA and RfOutB->RspB at its closing edge.
REQ-013 SHALL move CAPTURE -> WRITE if CmdWrite = 1, else CAPTURE -> RESP.
REQ-014 SHALL, in WRITE, drive FunSel = latched CmdFun and set exactly one enable bit for one cycle, then move to RESP.
REQ-015 SHALL use dst codes 000/001/010/011 -> RegSel 1000/0100/0010/0001, and 100/101/110/111 -> ScrSel 1000/0100/0010/0001.
REQ-016 SHALL hold RegSel = ScrSel = 0000 in every state except WRITE, and FunSel = 000 outside WRITE.
REQ-017 SHALL assert RspValid in RESP, hold RspA/RspB stable while RspValid = 1, and move RESP -> IDLE on the edge where RspReady = 1.
REQ-018 SHALL increment CmdCount by 1 at each RESP -> IDLE transition, wrapping 255 -> 0.
REQ-019 SHALL give RspA/RspB the pre-write contents even when Dst equals SrcA or SrcB, because capture precedes write.
REQ-020 SHALL have latency from handshake edge to RspValid high of 3 cycles with CmdWrite = 1 and 2 cycles with CmdWrite = 0; back-to-back throughput is one command per 4 (or 3) cycles plus RESP wait.
REQ-021 SHALL NOT lose or change its response when RspReady is held low indefinitely; CmdReady stays low during that time.

Reset
REQ-022 SHALL, on Reset high, immediately (asynchronously) force: IDLE, CmdReady 0, RspValid 0, RspA/RspB 0, OutASel/OutBSel 000, FunSel 000, RegSel/ScrSel 0000, CmdCount 0.
REQ-023 SHALL, if Reset asserts mid-command (including during WRITE), drop all enables at once, perform no further write, and produce no response for that command.
REQ-024 SHALL raise CmdReady in the first cycle after Reset deasserts.

Verification
REQ-025 Read-only: SrcA = 010, SrcB = 101, CmdWrite = 0, RfOutA = 0x1234_5678, RfOutB = 0xCAFE_0001 -> RspValid 2 cycles after handshake with those values; RegSel/ScrSel stay 0000 throughout; CmdCount 0 -> 1.
REQ-026 Write: Dst = 110, CmdFun = 011, CmdWrite = 1 -> exactly one cycle with ScrSel = 0010, FunSel = 011, RegSel = 0000; RspValid 3 cycles after handshake.
REQ-027 Backpressure: RspReady low for 10 cycles -> RspValid and RspA/RspB stable, CmdReady 0; then RspReady = 1 for one cycle -> IDLE, CmdReady 1 next cycle.
REQ-028 Reset during WRITE (Dst = 000) -> RegSel falls to 0000 asynchronously before the next edge, no response appears, CmdCount = 0.
REQ-029 Wrap and overlap: 256 completed read-only commands -> CmdCount = 0. Dst = SrcA = 001 with a write -> RspA equals the old R2 value.

Source files
------------

// File: rtl/rf_transfer_controller.sv
// Register-file transfer controller: accepts a read/optional-write command, selects the read ports,
// captures both operands, optionally issues a one-cycle write enable, then returns the captured data.
module rf_transfer_controller (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        CmdValid,
  output logic        CmdReady,
  input  logic [2:0]  CmdSrcA,
  input  logic [2:0]  CmdSrcB,
  input  logic [2:0]  CmdDst,
  input  logic [2:0]  CmdFun,
  input  logic        CmdWrite,
  input  logic [31:0] RfOutA,
  input  logic [31:0] RfOutB,
  output logic [2:0]  OutASel,
  output logic [2:0]  OutBSel,
  output logic [2:0]  FunSel,
  output logic [3:0]  RegSel,
  output logic [3:0]  ScrSel,
  output logic        RspValid,
  input  logic        RspReady,
  output logic [31:0] RspA,
  output logic [31:0] RspB,
  output logic [7:0]  CmdCount
);

  typedef enum logic [2:0] {StIdle, StSel, StCapture, StWrite, StResp} state_e;

  state_e      state_q, state_d;
  logic [2:0]  out_a_sel_q, out_a_sel_d;
  logic [2:0]  out_b_sel_q, out_b_sel_d;
  logic [2:0]  dst_q, dst_d;
  logic [2:0]  fun_q, fun_d;
  logic        wr_q, wr_d;
  logic [31:0] rsp_a_q, rsp_a_d;
  logic [31:0] rsp_b_q, rsp_b_d;
  logic [7:0]  count_q, count_d;
  logic        cmd_ready;
  logic        handshake;

  assign handshake = CmdValid & cmd_ready;

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (handshake) state_d = StSel;
      StSel:     state_d = StCapture;
      StCapture: state_d = wr_q ? StWrite : StResp;
      StWrite:   state_d = StResp;
      StResp:    if (RspReady) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // FSM outputs; enables depend only on state_q so an async reset drops them immediately
  always_comb begin
    cmd_ready = 1'b0;
    RspValid  = 1'b0;
    FunSel    = 3'b000;
    RegSel    = 4'b0000;
    ScrSel    = 4'b0000;
    unique case (state_q)
      StIdle:  cmd_ready = ~Reset;
      StWrite: begin
        FunSel = fun_q;
        if (dst_q[2]) ScrSel = 4'b1000 >> dst_q[1:0];
        else          RegSel = 4'b1000 >> dst_q[1:0];
      end
      StResp:  RspValid = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state: command latch, operand capture, completion count
  always_comb begin
    out_a_sel_d = out_a_sel_q;
    out_b_sel_d = out_b_sel_q;
    dst_d       = dst_q;
    fun_d       = fun_q;
    wr_d        = wr_q;
    rsp_a_d     = rsp_a_q;
    rsp_b_d     = rsp_b_q;
    count_d     = count_q;
    if (handshake) begin
      out_a_sel_d = CmdSrcA;
      out_b_sel_d = CmdSrcB;
      dst_d       = CmdDst;
      fun_d       = CmdFun;
      wr_d        = CmdWrite;
    end
    // Capture precedes the write, so a Dst matching a source still returns pre-write data
    if (state_q == StCapture) begin
      rsp_a_d = RfOutA;
      rsp_b_d = RfOutB;
    end
    if ((state_q == StResp) && RspReady) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      out_a_sel_q <= 3'b000;
      out_b_sel_q <= 3'b000;
      dst_q       <= 3'b000;
      fun_q       <= 3'b000;
      wr_q        <= 1'b0;
      rsp_a_q     <= 32'd0;
      rsp_b_q     <= 32'd0;
      count_q     <= 8'd0;
    end else begin
      out_a_sel_q <= out_a_sel_d;
      out_b_sel_q <= out_b_sel_d;
      dst_q       <= dst_d;
      fun_q       <= fun_d;
      wr_q        <= wr_d;
      rsp_a_q     <= rsp_a_d;
      rsp_b_q     <= rsp_b_d;
      count_q     <= count_d;
    end
  end

  assign CmdReady = cmd_ready;
  assign OutASel  = out_a_sel_q;
  assign OutBSel  = out_b_sel_q;
  assign RspA     = rsp_a_q;
  assign RspB     = rsp_b_q;
  assign CmdCount = count_q;

endmodule

// File: tb/tb_rf_transfer_controller.sv
// Directed self-checking bench for rf_transfer_controller.
module tb_rf_transfer_controller;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        CmdValid = 1'b0;
  logic        CmdReady;
  logic [2:0]  CmdSrcA = '0, CmdSrcB = '0, CmdDst = '0, CmdFun = '0;
  logic        CmdWrite = 1'b0;
  logic [31:0] RfOutA = '0, RfOutB = '0;
  logic [2:0]  OutASel, OutBSel, FunSel;
  logic [3:0]  RegSel, ScrSel;
  logic        RspValid;
  logic        RspReady = 1'b0;
  logic [31:0] RspA, RspB;
  logic [7:0]  CmdCount;

  int total = 0;
  int bad   = 0;

  rf_transfer_controller dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .CmdValid (CmdValid),
    .CmdReady (CmdReady),
    .CmdSrcA  (CmdSrcA),
    .CmdSrcB  (CmdSrcB),
    .CmdDst   (CmdDst),
    .CmdFun   (CmdFun),
    .CmdWrite (CmdWrite),
    .RfOutA   (RfOutA),
    .RfOutB   (RfOutB),
    .OutASel  (OutASel),
    .OutBSel  (OutBSel),
    .FunSel   (FunSel),
    .RegSel   (RegSel),
    .ScrSel   (ScrSel),
    .RspValid (RspValid),
    .RspReady (RspReady),
    .RspA     (RspA),
    .RspB     (RspB),
    .CmdCount (CmdCount)
  );

  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic issue(input logic [2:0] a, input logic [2:0] b, input logic [2:0] d,
                       input logic [2:0] f, input logic w);
    CmdSrcA  = a;
    CmdSrcB  = b;
    CmdDst   = d;
    CmdFun   = f;
    CmdWrite = w;
    CmdValid = 1'b1;
    tick();
    CmdValid = 1'b0;
  endtask

  // Read-only command with RspReady already high; checks the 2-cycle latency.
  task automatic do_read(input logic [2:0] a, input logic [2:0] b);
    int n;
    RspReady = 1'b1;
    issue(a, b, 3'd0, 3'd0, 1'b0);
    n = 0;
    while (!RspValid && n < 8) begin
      tick();
      n++;
    end
    check_eq("rd_lat", 32'(n), 32'd2);
    tick();
    RspReady = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    check_eq("rst_ready", 32'(CmdReady), 32'd0);
    check_eq("rst_valid", 32'(RspValid), 32'd0);
    check_eq("rst_rspa", RspA, 32'd0);
    check_eq("rst_rspb", RspB, 32'd0);
    check_eq("rst_outa", 32'(OutASel), 32'd0);
    check_eq("rst_regsel", 32'(RegSel), 32'd0);
    check_eq("rst_count", 32'(CmdCount), 32'd0);
    Reset = 1'b0;
    #1;
    check_eq("post_rst_ready", 32'(CmdReady), 32'd1);

    // Read-only command
    RfOutA = 32'h1234_5678;
    RfOutB = 32'hCAFE_0001;
    issue(3'b010, 3'b101, 3'b000, 3'b000, 1'b0);
    CmdSrcA = 3'b111;  // must be ignored
    check_eq("ro_sel_outa", 32'(OutASel), 32'd2);
    check_eq("ro_sel_outb", 32'(OutBSel), 32'd5);
    check_eq("ro_sel_ready", 32'(CmdReady), 32'd0);
    check_eq("ro_sel_valid", 32'(RspValid), 32'd0);
    tick();
    check_eq("ro_cap_outa", 32'(OutASel), 32'd2);
    check_eq("ro_cap_valid", 32'(RspValid), 32'd0);
    check_eq("ro_cap_sel", 32'({RegSel, ScrSel}), 32'd0);
    tick();
    check_eq("ro_rsp_valid", 32'(RspValid), 32'd1);
    check_eq("ro_rsp_a", RspA, 32'h1234_5678);
    check_eq("ro_rsp_b", RspB, 32'hCAFE_0001);
    check_eq("ro_rsp_sel", 32'({RegSel, ScrSel}), 32'd0);
    RspReady = 1'b1;
    tick();
    RspReady = 1'b0;
    check_eq("ro_idle_ready", 32'(CmdReady), 32'd1);
    check_eq("ro_idle_valid", 32'(RspValid), 32'd0);
    check_eq("ro_count", 32'(CmdCount), 32'd1);

    // Write to S3 with backpressure
    RfOutA = 32'h1111_1111;
    RfOutB = 32'h2222_2222;
    issue(3'b000, 3'b100, 3'b110, 3'b011, 1'b1);
    check_eq("wr_sel_scr", 32'(ScrSel), 32'd0);
    tick();
    check_eq("wr_cap_scr", 32'(ScrSel), 32'd0);
    check_eq("wr_cap_fun", 32'(FunSel), 32'd0);
    tick();
    check_eq("wr_scr", 32'(ScrSel), 32'b0010);
    check_eq("wr_fun", 32'(FunSel), 32'b011);
    check_eq("wr_reg", 32'(RegSel), 32'd0);
    check_eq("wr_valid", 32'(RspValid), 32'd0);
    tick();
    check_eq("wr_rsp_scr", 32'(ScrSel), 32'd0);
    check_eq("wr_rsp_fun", 32'(FunSel), 32'd0);
    check_eq("wr_rsp_valid", 32'(RspValid), 32'd1);
    RfOutA = 32'd0;
    RfOutB = 32'd0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("bp_valid", 32'(RspValid), 32'd1);
      check_eq("bp_a", RspA, 32'h1111_1111);
      check_eq("bp_b", RspB, 32'h2222_2222);
      check_eq("bp_ready", 32'(CmdReady), 32'd0);
    end
    RspReady = 1'b1;
    tick();
    RspReady = 1'b0;
    check_eq("bp_idle_ready", 32'(CmdReady), 32'd1);
    check_eq("bp_count", 32'(CmdCount), 32'd2);

    // Reset during WRITE to R1
    issue(3'b000, 3'b001, 3'b000, 3'b101, 1'b1);
    tick();
    tick();
    check_eq("rw_regsel", 32'(RegSel), 32'b1000);
    #2;
    Reset = 1'b1;
    #1;
    check_eq("rw_async_reg", 32'(RegSel), 32'd0);
    check_eq("rw_async_fun", 32'(FunSel), 32'd0);
    check_eq("rw_count", 32'(CmdCount), 32'd0);
    check_eq("rw_ready", 32'(CmdReady), 32'd0);
    tick();
    Reset = 1'b0;
    #1;
    check_eq("rw_ready_after", 32'(CmdReady), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("rw_no_rsp", 32'(RspValid), 32'd0);
      check_eq("rw_no_wr", 32'(RegSel), 32'd0);
    end

    // Count wrap
    for (int i = 0; i < 255; i++) do_read(3'(i), 3'(i + 1));
    check_eq("wrap_255", 32'(CmdCount), 32'd255);
    do_read(3'd3, 3'd4);
    check_eq("wrap_0", 32'(CmdCount), 32'd0);

    // Dst equals SrcA: response carries the pre-write R2 value
    RfOutA = 32'hAAAA_0001;
    RfOutB = 32'hBBBB_0002;
    issue(3'b001, 3'b010, 3'b001, 3'b010, 1'b1);
    tick();
    tick();
    check_eq("ov_regsel", 32'(RegSel), 32'b0100);
    RfOutA = 32'h5555_0001;
    tick();
    check_eq("ov_valid", 32'(RspValid), 32'd1);
    check_eq("ov_rsp_a", RspA, 32'hAAAA_0001);
    check_eq("ov_rsp_b", RspB, 32'hBBBB_0002);
    RspReady = 1'b1;
    tick();
    RspReady = 1'b0;
    check_eq("ov_count", 32'(CmdCount), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
